lpt_uart_bridge: RTL and testbench

LPT_UART_BRIDGE -- requirements
Module: lpt_uart_bridge

---
 rtl/lpt_pkg.sv | 21 ++
 rtl/uart_tx8n1.sv | 84 ++++++++
 rtl/lpt_uart_bridge.sv | 183 ++++++++++++++++++
 tb/tb_lpt_uart_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpt_pkg.sv
// Shared constants and state encodings for the Centronics-to-UART bridge.
package lpt_pkg;

  localparam int unsigned CLK_DIV_DEF  = 434;
  localparam int unsigned FIFO_AW_DEF  = 4;
  localparam int unsigned BUSY_MIN_DEF = 8;

  typedef enum logic [1:0] {
    STB_IDLE = 2'd0,
    STB_ACK  = 2'd1,
    STB_HOLD = 2'd2
  } stb_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx8n1.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, one stop bit.
module uart_tx8n1
  import lpt_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_e       state;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;

  // Each state lasts CLK_DIV cycles; div_cnt counts CLK_DIV-1 down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      ready   <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            shreg   <= data;
            txd     <= 1'b0;
            div_cnt <= DW'(CLK_DIV - 1);
            bit_cnt <= '0;
            ready   <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (div_cnt == '0) begin
            txd     <= shreg[0];
            div_cnt <= DW'(CLK_DIV - 1);
            state   <= TX_DATA;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        TX_DATA: begin
          if (div_cnt == '0) begin
            div_cnt <= DW'(CLK_DIV - 1);
            if (bit_cnt == 4'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        TX_STOP: begin
          if (div_cnt == '0) begin
            ready <= 1'b1;
            state <= TX_IDLE;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          ready <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lpt_uart_bridge.sv
// Centronics parallel printer port to UART bridge with a byte FIFO,
// strobe/busy handshake, CTS flow control and printer-init flush.
module lpt_uart_bridge
  import lpt_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned FIFO_AW  = FIFO_AW_DEF,
  parameter int unsigned BUSY_MIN = BUSY_MIN_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [7:0]       lp_data,
  input  logic             lp_stb_n,
  input  logic             lp_init_n,
  output logic             lp_busy,
  output logic             lp_err_n,
  output logic             txd,
  input  logic             cts_n,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned BW    = $clog2(BUSY_MIN + 1);

  logic [1:0]         stb_sync;
  logic [1:0]         init_sync;
  logic [1:0]         cts_sync;
  logic               stb_s;
  logic               init_s;
  logic               cts_s;
  logic               stb_q;
  logic [1:0]         settle;

  stb_state_e         stb_state;
  logic [BW-1:0]      busy_cnt;
  logic               ovf;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [LW-1:0]      count_nxt;
  logic               full;
  logic               full_nxt;
  logic               empty;
  logic               push_req;
  logic               push;
  logic               pop;

  logic               tx_ready;
  logic               tx_rst;
  logic [7:0]         tx_data;

  // Control inputs cross into wb_clk_i; lp_data is stable by the time a strobe is seen.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stb_sync  <= 2'b11;
      init_sync <= 2'b11;
      cts_sync  <= 2'b11;
      stb_q     <= 1'b1;
      settle    <= 2'b00;
    end else begin
      stb_sync  <= {stb_sync[0], lp_stb_n};
      init_sync <= {init_sync[0], lp_init_n};
      cts_sync  <= {cts_sync[0], cts_n};
      stb_q     <= stb_sync[1];
      settle    <= {settle[0], 1'b1};
    end
  end

  assign stb_s  = stb_sync[1];
  assign init_s = init_sync[1];
  assign cts_s  = cts_sync[1];

  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == LW'(DEPTH));
  assign push_req  = (stb_state == STB_IDLE) && stb_q && !stb_s;
  assign push      = push_req && !full && init_s;
  assign pop       = tx_ready && !empty && !cts_s && init_s;
  assign count_nxt = fifo_level + LW'(push) - LW'(pop);
  assign full_nxt  = (count_nxt == LW'(DEPTH));

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= lp_data;
    end
  end

  assign tx_data = mem[rd_ptr];

  // Strobe handshake FSM plus FIFO pointer/level bookkeeping.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stb_state  <= STB_IDLE;
      busy_cnt   <= '0;
      lp_busy    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else if (!init_s) begin
      stb_state  <= STB_IDLE;
      busy_cnt   <= '0;
      lp_busy    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      fifo_level <= count_nxt;
      if (push_req && full) begin
        ovf <= 1'b1;
      end

      case (stb_state)
        STB_IDLE: begin
          if (push_req) begin
            busy_cnt  <= '0;
            lp_busy   <= 1'b1;
            stb_state <= STB_ACK;
          end else begin
            // Busy also covers a full FIFO and the post-reset settle window.
            lp_busy <= full_nxt || !settle[1];
          end
        end
        STB_ACK: begin
          lp_busy <= 1'b1;
          if (busy_cnt != BW'(BUSY_MIN)) begin
            busy_cnt <= busy_cnt + BW'(1);
          end
          if (stb_s) begin
            stb_state <= STB_HOLD;
          end
        end
        STB_HOLD: begin
          if (busy_cnt != BW'(BUSY_MIN)) begin
            busy_cnt <= busy_cnt + BW'(1);
          end
          if (stb_s && !full && (busy_cnt >= BW'(BUSY_MIN - 1))) begin
            lp_busy   <= !settle[1];
            stb_state <= STB_IDLE;
          end else begin
            lp_busy <= 1'b1;
          end
        end
        default: begin
          lp_busy   <= 1'b1;
          stb_state <= STB_IDLE;
        end
      endcase
    end
  end

  // Error line is low while the receiver is not ready or after an overflow.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lp_err_n <= 1'b0;
    end else begin
      lp_err_n <= !cts_s && !ovf;
    end
  end

  // Init holds the transmitter in reset so any frame in flight is cut short.
  assign tx_rst = wb_rst_i || !init_s;

  uart_tx8n1 #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (wb_clk_i),
    .rst   (tx_rst),
    .start (pop),
    .data  (tx_data),
    .ready (tx_ready),
    .txd   (txd)
  );

endmodule

// File: tb/tb_lpt_uart_bridge.sv
// Directed bench for lpt_uart_bridge: handshake timing, flow control, wrap, init abort, reset.
module tb_lpt_uart_bridge;

  localparam int unsigned CLK_DIV  = 16;
  localparam int unsigned FIFO_AW  = 4;
  localparam int unsigned BUSY_MIN = 8;

  typedef struct {
    logic [7:0] data;
    logic [4:0] exp_level;
    logic       exp_busy;
  } vec_t;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic [7:0]       lp_data   = 8'h00;
  logic             lp_stb_n  = 1'b1;
  logic             lp_init_n = 1'b1;
  logic             cts_n     = 1'b0;
  logic             lp_busy;
  logic             lp_err_n;
  logic             txd;
  logic [FIFO_AW:0] fifo_level;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] rx_q[$];
  logic [9:0] mon_fr;
  logic [7:0] exp_q[$];
  bit         mon_en    = 1'b0;
  bit         track_en  = 1'b0;
  int         max_level = 0;
  vec_t       tbl[16];

  always #5 clk = ~clk;

  lpt_uart_bridge #(
    .CLK_DIV  (CLK_DIV),
    .FIFO_AW  (FIFO_AW),
    .BUSY_MIN (BUSY_MIN)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .lp_data    (lp_data),
    .lp_stb_n   (lp_stb_n),
    .lp_init_n  (lp_init_n),
    .lp_busy    (lp_busy),
    .lp_err_n   (lp_err_n),
    .txd        (txd),
    .cts_n      (cts_n),
    .fifo_level (fifo_level)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Serial receiver: samples each bit mid-cell and records the 10-bit frame.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        mon_fr[0] = txd;
        for (int b = 1; b < 10; b++) begin
          repeat (CLK_DIV) @(negedge clk);
          mon_fr[b] = txd;
        end
        if (mon_en) rx_q.push_back(mon_fr);
      end
    end
  end

  always @(negedge clk) begin
    if (track_en && int'(fifo_level) > max_level) max_level <= int'(fifo_level);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_busy_low();
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = !lp_busy;
    end
    check("busy_low_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input int n, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = (rx_q.size() >= n);
    end
    check("rx_frame_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_txd_low();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (txd == 1'b0);
    end
    check("txd_start_wait", 32'(ok), 32'd1);
  endtask

  task automatic strobe(input logic [7:0] d);
    wait_busy_low();
    @(posedge clk);
    #1;
    lp_data  = d;
    lp_stb_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 lp_stb_n = 1'b1;
  endtask

  task automatic release_check(input string tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_busy_c1"}, 32'(lp_busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_c2"}, 32'(lp_busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_c3"}, 32'(lp_busy), 32'd0);
  endtask

  task automatic count_txd_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd == 1'b0) lows++;
    end
  endtask

  initial begin
    int hi;
    int lows;
    logic [9:0] fr;

    for (int i = 0; i < 16; i++) begin
      tbl[i].data      = 8'(i);
      tbl[i].exp_level = 5'(i + 1);
      tbl[i].exp_busy  = (i == 15);
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(lp_busy), 32'd1);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_err_n", 32'(lp_err_n), 32'd0);
    release_check("rel");
    check("rel_err_n", 32'(lp_err_n), 32'd1);
    mon_en = 1'b1;

    // Single byte transfer
    @(posedge clk);
    #1;
    lp_data  = 8'hA5;
    lp_stb_n = 1'b0;
    repeat (3) @(negedge clk);
    check("xfer_busy_pre", 32'(lp_busy), 32'd0);
    @(negedge clk);
    check("xfer_busy_rise", 32'(lp_busy), 32'd1);
    check("xfer_level", 32'(fifo_level), 32'd1);
    @(posedge clk);
    #1 lp_stb_n = 1'b1;
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lp_busy) hi++;
      else break;
    end
    check("xfer_busy_width", 32'(hi), 32'(BUSY_MIN));
    wait_rx(1, 400);
    if (rx_q.size() >= 1) check("xfer_frame", 32'(rx_q[0]), 32'({1'b1, 8'hA5, 1'b0}));
    rx_q.delete();

    // Flow control: receiver not ready, fill the FIFO
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      strobe(tbl[i].data);
      repeat (9) @(negedge clk);
      check($sformatf("flow_level[%0d]", i), 32'(fifo_level), 32'(tbl[i].exp_level));
      check($sformatf("flow_busy[%0d]", i), 32'(lp_busy), 32'(tbl[i].exp_busy));
      check($sformatf("flow_err_n[%0d]", i), 32'(lp_err_n), 32'd0);
      check($sformatf("flow_txd[%0d]", i), 32'(txd), 32'd1);
    end
    repeat (30) @(negedge clk);
    check("flow_full_busy_hold", 32'(lp_busy), 32'd1);
    cts_n = 1'b0;
    wait_rx(16, 3000);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_q.size()) begin
        fr = rx_q[i];
        check($sformatf("flow_rx[%0d]", i), 32'(fr[8:1]), 32'(i));
      end
    end
    check("flow_drained_level", 32'(fifo_level), 32'd0);
    rx_q.delete();

    // Second strobe edge while the handshake is still busy
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    lp_data  = 8'h3C;
    lp_stb_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 lp_stb_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lp_data  = 8'hC3;
    lp_stb_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 lp_stb_n = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_level", 32'(fifo_level), 32'd1);
    check("glitch_busy", 32'(lp_busy), 32'd1);
    wait_busy_low();
    check("glitch_level_after", 32'(fifo_level), 32'd1);
    cts_n = 1'b0;
    wait_rx(1, 400);
    if (rx_q.size() >= 1) begin
      fr = rx_q[0];
      check("glitch_rx_data", 32'(fr[8:1]), 32'h3C);
    end
    repeat (200) @(negedge clk);
    check("glitch_rx_count", 32'(rx_q.size()), 32'd1);
    rx_q.delete();

    // Wrap-around through a draining FIFO
    max_level = 0;
    track_en  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(i * 37 + 5));
      strobe(8'(i * 37 + 5));
    end
    wait_rx(40, 8000);
    track_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i < rx_q.size()) begin
        fr = rx_q[i];
        check($sformatf("wrap_rx[%0d]", i), 32'(fr[8:1]), 32'(exp_q[i]));
      end
    end
    check("wrap_max_le_depth", 32'(max_level <= 16), 32'd1);
    check("wrap_max_reached", 32'(max_level), 32'd16);
    rx_q.delete();

    // Init asserted mid-frame with bytes queued
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) strobe(8'(i * 8'h11));
    wait_busy_low();
    check("init_level_pre", 32'(fifo_level), 32'd6);
    cts_n = 1'b0;
    wait_txd_low();
    repeat (48) @(negedge clk);
    check("init_txd_pre", 32'(txd), 32'd0);
    check("init_level_queued", 32'(fifo_level), 32'd5);
    mon_en = 1'b0;
    @(posedge clk);
    #1 lp_init_n = 1'b0;
    repeat (3) @(negedge clk);
    check("init_txd_idle", 32'(txd), 32'd1);
    @(negedge clk);
    check("init_level_flush", 32'(fifo_level), 32'd0);
    check("init_busy", 32'(lp_busy), 32'd1);
    repeat (6) @(posedge clk);
    #1 lp_init_n = 1'b1;
    repeat (3) @(negedge clk);
    check("init_rel_busy_hold", 32'(lp_busy), 32'd1);
    @(negedge clk);
    check("init_rel_busy_fall", 32'(lp_busy), 32'd0);
    count_txd_low(200, lows);
    check("init_no_resume", 32'(lows), 32'd0);
    check("init_level_post", 32'(fifo_level), 32'd0);
    rx_q.delete();

    // Reset pulse during a frame
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    strobe(8'h00);
    strobe(8'h77);
    wait_busy_low();
    cts_n = 1'b0;
    wait_txd_low();
    repeat (40) @(negedge clk);
    check("mrst_txd_pre", 32'(txd), 32'd0);
    check("mrst_level_pre", 32'(fifo_level), 32'd1);
    check("mrst_busy_pre", 32'(lp_busy), 32'd0);
    check("mrst_err_n_pre", 32'(lp_err_n), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(lp_busy), 32'd1);
    check("mrst_txd", 32'(txd), 32'd1);
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_err_n", 32'(lp_err_n), 32'd0);
    repeat (3) @(negedge clk);
    release_check("mrst_rel");
    count_txd_low(60, lows);
    check("mrst_txd_quiet", 32'(lows), 32'd0);
    check("mrst_level_post", 32'(fifo_level), 32'd0);
    check("mrst_err_n_post", 32'(lp_err_n), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
